lbp_gray_host: RTL and testbench
================================

// Module: lbp_gray_host
// PURPOSE
//  Responder side of the gray-image / LBP-result interface. Owns a 128x128x8 gray image
//  memory and a 128x128x8 LBP result memory. Serves combinational reads to the LBP engine,
//  captures its result writes and reports completion and protocol errors. Used as the
//  on-chip host for the LBP engine and as its self-checking harness.
// PARAMETERS
//  ADDR_W   14     pixel address width, {row[6:0], col[6:0]}
//  DATA_W   8      pixel / LBP code width
//  EXP_WR   15876  expected result writes per frame (126*126 interior pixels)
// PORTS
//  clk         in   1       rising-edge clock
//  reset_n     in   1       asynchronous active-low reset
//  load_en     in   1       image load strobe (honoured in IDLE only)
//  load_addr   in   ADDR_W  image load address
//  load_data   in   DATA_W  image load data
//  start       in   1       begin serving a frame (IDLE only)
//  clear       in   1       return DONE -> IDLE, clear counters/flags
//  gray_ready  out  1       host ready to serve gray reads
//  gray_req    in   1       engine read request
//  gray_addr   in   ADDR_W  engine read address
//  gray_data   out  DATA_W  image[gray_addr], combinational
//  lbp_valid   in   1       engine result write strobe
//  lbp_addr    in   ADDR_W  result address
//  lbp_data    in   DATA_W  result code
//  finish      in   1       engine end-of-frame
//  done        out  1       frame complete (DONE state)
//  wr_cnt      out  14      accepted result writes this frame
//  err_border  out  1       sticky: write to row/col 0 or 127
//  err_count   out  1       sticky: finish with wr_cnt != EXP_WR
//  err_proto   out  1       sticky: lbp_valid/finish outside SERVE
//  res_addr    in   ADDR_W  result readback address
//  res_data    out  DATA_W  result[res_addr], combinational
//  rd_cnt      out  18      served read count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; gray_ready=0, done=0, wr_cnt=0, all err_*=0, rd_cnt=0.
//   Memories are not reset; contents survive reset.
//  FSM: IDLE -start-> SERVE -finish-> DONE -clear-> IDLE. Other inputs hold state.
//   start in SERVE/DONE and clear in IDLE/SERVE are ignored.
//  IDLE: load_en writes image[load_addr] <= load_data on the clock edge.
//   gray_ready=0. Results are still readable via res_addr.
//  SERVE: gray_ready=1; load_en ignored.
//   gray_data = image[gray_addr] combinationally whenever gray_req=1; 0 when gray_req=0.
//   The engine registers gray_addr and samples gray_data in the following cycle, so
//   reads carry zero added latency.
//   lbp_valid=1 -> result[lbp_addr] <= lbp_data and wr_cnt+1 (saturates at 16383).
//   If lbp_addr row or col is 0 or 127: err_border is set, but the write is still
//   performed.
//  finish: level input, acted on only at the first SERVE cycle where it is high.
//   If lbp_valid and finish are high in the same cycle, the write is counted before the
//   count check. err_count is set if the final wr_cnt != EXP_WR. Next state is DONE.
//  DONE: done=1, gray_ready=0, gray_data=0. Further lbp_valid is dropped and sets
//   err_proto; a high finish level does not set err_proto.
//   clear -> IDLE, zeroing wr_cnt, rd_cnt and err_*.
//  lbp_valid in IDLE is dropped and sets err_proto.
//  Address wrap: none. ADDR_W covers all 16384 locations exactly.
//  Reset mid-SERVE: the FSM aborts to IDLE with counters cleared. Partial results stay
//   in memory.
// CONFIGURATION
//  LBP_HOST_RDCNT_EN defined: rd_cnt counts SERVE cycles with gray_req=1, saturating
//   at 2^18-1, cleared by reset and clear.
//  LBP_HOST_RDCNT_EN undefined: rd_cnt tied to 0 and no counter logic is built.
// TESTING
//  1 Load ramp image[a]=a[7:0], start, gray_req=1, gray_addr=14'h0081
//     -> gray_data=8'h81 in the same cycle.
//  2 Full frame with a reference LBP engine -> done=1, wr_cnt=15876, all err_*=0;
//     result[{7'd1,7'd1}] matches golden.
//  3 lbp_valid with lbp_addr=14'h0000 in SERVE -> err_border=1 and result[0] written.
//  4 finish after 100 writes -> DONE, err_count=1, wr_cnt=100.
//     clear -> IDLE with wr_cnt=0 and err_count=0.
//  5 lbp_valid+finish in the same cycle as write 15876 -> wr_cnt=15876, err_count=0.
//     lbp_valid one cycle later -> err_proto=1.
//  6 reset_n low mid-SERVE -> gray_ready=0 within the same cycle, state IDLE.
//     Image survives: after start, gray_data for addr 5 = 8'h05.
//     With LBP_HOST_RDCNT_EN defined, rd_cnt=0.

Source files
------------

// File: rtl/lbp_gray_host.sv
// lbp_gray_host: on-chip responder for an LBP engine.
// Holds a 128x128x8 gray image and a 128x128x8 result memory.
// Ports: clk, reset_n (async, active low); load_en/load_addr/load_data
//   fill the image in IDLE; start/clear drive the frame FSM;
//   gray_ready/gray_req/gray_addr/gray_data serve zero-latency reads;
//   lbp_valid/lbp_addr/lbp_data/finish capture results;
//   done, wr_cnt, err_border, err_count, err_proto report status;
//   res_addr/res_data read results back; rd_cnt counts served reads.
// Optional macro LBP_HOST_RDCNT_EN builds the rd_cnt counter,
//   otherwise rd_cnt is tied to zero.
module lbp_gray_host #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int EXP_WR = 15876
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic              clear,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [DATA_W-1:0] gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [DATA_W-1:0] lbp_data,
    input  logic              finish,
    output logic              done,
    output logic [13:0]       wr_cnt,
    output logic              err_border,
    output logic              err_count,
    output logic              err_proto,
    input  logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_data,
    output logic [17:0]       rd_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int HW    = ADDR_W / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;

    logic [DATA_W-1:0] image  [DEPTH];
    logic [DATA_W-1:0] result [DEPTH];

    logic [HW-1:0] wr_row;
    logic [HW-1:0] wr_col;
    logic          border;
    logic [13:0]   wr_inc;
    logic [13:0]   wr_next;

    assign wr_row = lbp_addr[ADDR_W-1:HW];
    assign wr_col = lbp_addr[HW-1:0];
    assign border = (wr_row == '0) || (wr_row == '1) ||
                    (wr_col == '0) || (wr_col == '1);

    assign wr_inc  = (wr_cnt == 14'h3fff) ? wr_cnt : wr_cnt + 14'd1;
    // A write landing in the finish cycle is part of the final count.
    assign wr_next = lbp_valid ? wr_inc : wr_cnt;

    // Memories are deliberately not reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (load_en && state == IDLE)
            image[load_addr] <= load_data;
        if (lbp_valid && state == SERVE)
            result[lbp_addr] <= lbp_data;
    end

    assign gray_data = (state == SERVE && gray_req) ? image[gray_addr] : '0;
    assign res_data  = result[res_addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            gray_ready <= 1'b0;
            done       <= 1'b0;
            wr_cnt     <= '0;
            err_border <= 1'b0;
            err_count  <= 1'b0;
            err_proto  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (lbp_valid || finish)
                        err_proto <= 1'b1;
                    if (start) begin
                        state      <= SERVE;
                        gray_ready <= 1'b1;
                    end
                end
                SERVE: begin
                    if (lbp_valid) begin
                        wr_cnt <= wr_next;
                        if (border)
                            err_border <= 1'b1;
                    end
                    if (finish) begin
                        state      <= DONE;
                        gray_ready <= 1'b0;
                        done       <= 1'b1;
                        if (wr_next != 14'(EXP_WR))
                            err_count <= 1'b1;
                    end
                end
                DONE: begin
                    if (lbp_valid)
                        err_proto <= 1'b1;
                    if (clear) begin
                        state      <= IDLE;
                        done       <= 1'b0;
                        wr_cnt     <= '0;
                        err_border <= 1'b0;
                        err_count  <= 1'b0;
                        err_proto  <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    gray_ready <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

`ifdef LBP_HOST_RDCNT_EN
    logic [17:0] rd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rd_q <= '0;
        else if (state == DONE && clear)
            rd_q <= '0;
        else if (state == SERVE && gray_req && rd_q != '1)
            rd_q <= rd_q + 18'd1;
    end

    assign rd_cnt = rd_q;
`else
    assign rd_cnt = '0;
`endif

endmodule

// File: tb/tb_lbp_gray_host.sv
// tb_lbp_gray_host: directed bench for lbp_gray_host.
// Expected values are queued as stimulus is driven and popped at sampling.
module tb_lbp_gray_host;

    logic        clk;
    logic        reset_n;
    logic        load_en;
    logic [13:0] load_addr;
    logic [7:0]  load_data;
    logic        start;
    logic        clear;
    logic        gray_ready;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic [7:0]  gray_data;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    logic        done;
    logic [13:0] wr_cnt;
    logic        err_border;
    logic        err_count;
    logic        err_proto;
    logic [13:0] res_addr;
    logic [7:0]  res_data;
    logic [17:0] rd_cnt;

    lbp_gray_host dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .clear      (clear),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .done       (done),
        .wr_cnt     (wr_cnt),
        .err_border (err_border),
        .err_count  (err_count),
        .err_proto  (err_proto),
        .res_addr   (res_addr),
        .res_data   (res_data),
        .rd_cnt     (rd_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_vec++;
        if (q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h expected entry", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int r, input int c);
        logic [13:0] a;
        a = 14'((r << 7) | c);
        return a[7:0];
    endfunction

    function automatic logic [7:0] lbp(input int r, input int c,
                                       input logic [7:0] ctr);
        int dr[8];
        int dc[8];
        logic [7:0] code;
        dr = '{-1, -1, -1, 0, 1, 1, 1, 0};
        dc = '{-1, 0, 1, 1, 1, 0, -1, -1};
        code = '0;
        for (int k = 0; k < 8; k++)
            code[7-k] = (pix(r + dr[k], c + dc[k]) >= ctr);
        return code;
    endfunction

    function automatic logic [13:0] iaddr(input int i);
        int r;
        int c;
        r = 1 + i / 126;
        c = 1 + i % 126;
        return 14'((r << 7) | c);
    endfunction

    initial begin
        int r;
        int c;
        logic [7:0] g11;

        reset_n   = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        clear     = 1'b0;
        gray_req  = 1'b0;
        gray_addr = '0;
        lbp_valid = 1'b0;
        lbp_addr  = '0;
        lbp_data  = '0;
        finish    = 1'b0;
        res_addr  = '0;

        // Reset state
        push("rst_gray_ready", 0);
        push("rst_done", 0);
        push("rst_wr_cnt", 0);
        push("rst_errs", 0);
        push("rst_rd_cnt", 0);
        #3;
        pop_chk(32'(gray_ready));
        pop_chk(32'(done));
        pop_chk(32'(wr_cnt));
        pop_chk(32'({err_border, err_count, err_proto}));
        pop_chk(32'(rd_cnt));
        #9 reset_n = 1'b1;
        step();

        // Ramp image load in IDLE
        for (int a = 0; a < 16384; a++) begin
            load_en   = 1'b1;
            load_addr = 14'(a);
            load_data = 8'(a);
            step();
        end
        load_en = 1'b0;

        // Zero-latency read
        start = 1'b1;
        step();
        start = 1'b0;
        push("serve_gray_ready", 1);
        pop_chk(32'(gray_ready));
        gray_req  = 1'b1;
        gray_addr = 14'h0081;
        push("read_0081", 8'h81);
        #1 pop_chk(32'(gray_data));
        gray_req = 1'b0;
        push("read_noreq", 0);
        #1 pop_chk(32'(gray_data));
        step();

        // Border write, then 100 writes and a short-count finish
        lbp_valid = 1'b1;
        lbp_addr  = 14'h0000;
        lbp_data  = 8'ha5;
        step();
        lbp_valid = 1'b0;
        res_addr  = 14'h0000;
        push("err_border_set", 1);
        push("border_result", 8'ha5);
        #1;
        pop_chk(32'(err_border));
        pop_chk(32'(res_data));
        for (int i = 1; i < 100; i++) begin
            lbp_valid = 1'b1;
            lbp_addr  = iaddr(i);
            lbp_data  = 8'(i);
            step();
        end
        lbp_valid = 1'b0;
        finish    = 1'b1;
        step();
        finish = 1'b0;
        push("short_done", 1);
        push("short_wr_cnt", 100);
        push("short_err_count", 1);
        pop_chk(32'(done));
        pop_chk(32'(wr_cnt));
        pop_chk(32'(err_count));
        clear = 1'b1;
        step();
        clear = 1'b0;
        push("clear_done", 0);
        push("clear_wr_cnt", 0);
        push("clear_errs", 0);
        pop_chk(32'(done));
        pop_chk(32'(wr_cnt));
        pop_chk(32'({err_border, err_count, err_proto}));

        // Full frame; last write shares its cycle with finish
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 15876; i++) begin
            r = 1 + i / 126;
            c = 1 + i % 126;
            gray_req  = 1'b1;
            gray_addr = iaddr(i);
            #1;
            if (i % 2000 == 7) begin
                push("frame_gray", 32'(pix(r, c)));
                pop_chk(32'(gray_data));
            end
            lbp_valid = 1'b1;
            lbp_addr  = iaddr(i);
            lbp_data  = lbp(r, c, gray_data);
            finish    = (i == 15875);
            step();
        end
        lbp_valid = 1'b0;
        finish    = 1'b0;
        push("frame_done", 1);
        push("frame_wr_cnt", 15876);
        push("frame_errs", 0);
        push("frame_gray_ready", 0);
        push("done_gray_data", 0);
        pop_chk(32'(done));
        pop_chk(32'(wr_cnt));
        pop_chk(32'({err_border, err_count, err_proto}));
        pop_chk(32'(gray_ready));
        #1 pop_chk(32'(gray_data));
        gray_req = 1'b0;
        g11 = lbp(1, 1, pix(1, 1));
        res_addr = {7'd1, 7'd1};
        push("golden_1_1", 32'(g11));
        #1 pop_chk(32'(res_data));
        res_addr = {7'd126, 7'd126};
        push("golden_126_126", 32'(lbp(126, 126, pix(126, 126))));
        #1 pop_chk(32'(res_data));
        res_addr = {7'd64, 7'd37};
        push("golden_64_37", 32'(lbp(64, 37, pix(64, 37))));
        #1 pop_chk(32'(res_data));

        // Late write in DONE is dropped and flagged
        lbp_valid = 1'b1;
        lbp_addr  = {7'd1, 7'd1};
        lbp_data  = ~g11;
        step();
        lbp_valid = 1'b0;
        res_addr  = {7'd1, 7'd1};
        push("late_err_proto", 1);
        push("late_dropped", 32'(g11));
        push("late_wr_cnt", 15876);
        #1;
        pop_chk(32'(err_proto));
        pop_chk(32'(res_data));
        pop_chk(32'(wr_cnt));
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Reset in the middle of SERVE
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gray_req  = 1'b1;
            gray_addr = 14'd5;
            lbp_valid = 1'b1;
            lbp_addr  = iaddr(i);
            lbp_data  = 8'h3c;
            step();
        end
        gray_req  = 1'b0;
        lbp_valid = 1'b0;
        push("pre_rst_wr_cnt", 3);
        pop_chk(32'(wr_cnt));
`ifdef LBP_HOST_RDCNT_EN
        push("pre_rst_rd_cnt", 3);
        pop_chk(32'(rd_cnt));
`endif
        #2 reset_n = 1'b0;
        push("mid_rst_gray_ready", 0);
        push("mid_rst_wr_cnt", 0);
        push("mid_rst_rd_cnt", 0);
        #1;
        pop_chk(32'(gray_ready));
        pop_chk(32'(wr_cnt));
        pop_chk(32'(rd_cnt));
        #2 reset_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        gray_req  = 1'b1;
        gray_addr = 14'd5;
        push("survive_addr5", 8'h05);
        #1 pop_chk(32'(gray_data));
        res_addr = iaddr(1);
        push("partial_result", 8'h3c);
        #1 pop_chk(32'(res_data));
        gray_req = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
